inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction assembler for the pipeline's instruction-memory preload path: accepts decoded instruction fields (format, opcode, registers, functs, full-width immediate) over a valid/ready handshake and packs them into 32-bit RV32I words. It places each immediate into exactly the bit positions the decode-stage immediate extractor reads back. Each word is streamed out with an auto-incrementing byte address for writing into IMEM. It is the write-side counterpart of immediate extraction; out-of-range immediates are rejected and counted.

## Interface
- ADDR_W, 12 — width of output byte address
- BASE_ADDR, 0 — first output address after reset/clear (word aligned)
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- clr  in  1  synchronous clear of address, counters, output register
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept
- in_fmt  in  3  format code: R, I, S, B, U, J (enum in package)
- in_opcode  in  7  placed at [6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed immediate value (byte offset for B/J; full value for U)
- out_valid  out  1  packed word valid
- out_ready  in  1  IMEM writer accepts
- out_inst  out  32  packed instruction
- out_addr  out  ADDR_W  byte address of out_inst
- inst_count  out  16  words emitted since reset/clear (wraps)
- err  out  1  sticky: at least one bundle rejected
- err_count  out  8  rejected bundles, saturates at 255

## Operation
- Packing (imm = in_imm):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Fields unused by a format are ignored; in_imm is ignored for R.
- Reserved in_fmt codes are rejected like range errors.
- Rejected bundle: consumed (handshake completes), no output word, address unchanged, err set, err_count increments (saturating).
- Accepted word: out_addr holds the address for it; after the out handshake, address += 4 modulo 2^ADDR_W, and inst_count += 1.

## Timing
- Reset/clear values: out_valid 0, out_inst 0, out_addr BASE_ADDR, inst_count 0, err 0, err_count 0.
- Single output register, latency 1: bundle accepted at edge N appears on out_valid/out_inst at N+1.
- in_ready = !out_valid || out_ready (combinational), so back-to-back throughput is 1 word/cycle under continuous out_ready.
- out_valid held, out_inst/out_addr stable, while out_ready low.
- Same-cycle out handshake and new accept: register reloads, address advances once.
- clr has priority over any handshake that cycle; the held word and incoming bundle are dropped (not counted as errors).
- rst_n asserted mid-stream: identical to clr, plus all state to reset values.
- Address wrap: (2^ADDR_W - 4) + 4 yields 0, not BASE_ADDR.

## Configuration
- INST_ENC_RANGE_CHECK_EN defined: reject when the value is out of range —
  - I/S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094] or imm[0] != 0.
  - J: imm not in [-2^20, 2^20-2] or imm[0] != 0.
  - U: imm[11:0] != 0.
- Undefined: no range checks; immediates are silently truncated to their field bits; only reserved in_fmt sets err.

## Structure
- Package inst_enc_pkg: fmt enum (R=0, I=1, S=2, B=3, U=4, J=5), opcode constants, per-format immediate min/max localparams.
- Sub-module inst_pack: purely combinational packer/range checker (fields in, word + reject out); the top holds the handshake, output register and counters.

## Test plan
- I, opcode 0x13, rd 1, rs1 0, f3 0, imm 5 -> out_inst 0x00500093 at out_addr BASE_ADDR, one cycle later.
- S, opcode 0x23, rs1 1, rs2 2, f3 2, imm 8 -> 0x0020A423; B, opcode 0x63, rs1 1, rs2 2, imm -4 -> 0xFE208EE3.
- J, opcode 0x6F, rd 1, imm 2048 -> 0x001000EF; U, opcode 0x37, rd 5, imm 0x12345000 -> 0x123452B7.
- With macro: I imm 2048, then B imm 3 -> no output, err 1, err_count 2, out_addr unchanged; without macro, I imm 2048 -> 0x80000093.
- out_ready low 3 cycles with in_valid held -> in_ready 0, out_inst stable; release -> continuous 1 word/cycle, addresses step by 4, wrap 0xFFC -> 0x000 (ADDR_W 12).
- clr while out_valid high and in_valid high -> out_valid 0 next cycle, out_addr BASE_ADDR, inst_count 0, err_count 0.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg -- shared types and constants for the instruction assembler.
//   inst_fmt_e : instruction format codes carried on in_fmt (6 and 7 are reserved)
//   OPC_*      : RV32I base opcodes, for use by producers of field bundles
//   IMM_*      : signed immediate limits applied when INST_ENC_RANGE_CHECK_EN is defined
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } inst_fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // I- and S-type share one 12-bit signed field.
  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  // B and J are even byte offsets; the max is the largest even value.
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -(1 << 20);
  localparam int IMM_J_MAX  = (1 << 20) - 2;

endpackage

// File: rtl/inst_pack.sv
// inst_pack -- combinational RV32I packer and immediate checker.
//   fmt_i                    : format code (inst_fmt_e), reserved codes rejected
//   opcode_i, rd_i, rs1_i,
//   rs2_i, funct3_i, funct7_i: instruction fields
//   imm_i                    : signed immediate (byte offset for B/J, full value for U)
//   inst_o                   : packed 32-bit instruction
//   reject_o                 : bundle must be dropped
// Optional feature: INST_ENC_RANGE_CHECK_EN enables immediate range/alignment
// rejection; without it immediates are truncated to their field bits.
module inst_pack (
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        reject_o
);
  import inst_enc_pkg::*;

  logic fmt_bad;
  logic range_bad;

  always_comb begin
    inst_o  = '0;
    fmt_bad = 1'b0;
    case (fmt_i)
      FMT_R: inst_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: inst_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm_i);

  always_comb begin
    range_bad = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_bad = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
      FMT_B:        range_bad = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm_i[0];
      FMT_J:        range_bad = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm_i[0];
      FMT_U:        range_bad = (imm_i[11:0] != '0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign reject_o = fmt_bad || range_bad;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder -- assembles decoded instruction fields into RV32I words and
// streams them with an auto-incrementing byte address for IMEM preload.
//   clk, rst_n (sync, active low), clr (sync clear of address/counters/output)
//   in_valid/in_ready + in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//   in_funct3, in_funct7, in_imm : field bundle handshake
//   out_valid/out_ready + out_inst, out_addr : packed word stream
//   inst_count : words emitted since reset/clear (wraps)
//   err, err_count : sticky reject flag, saturating reject count
// Optional feature: INST_ENC_RANGE_CHECK_EN (immediate range checks in inst_pack).
module inst_encoder #(
  parameter int unsigned           ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       inst_count,
  output logic              err,
  output logic [7:0]        err_count
);
  import inst_enc_pkg::*;

  logic [31:0]       pack_inst;
  logic              pack_reject;

  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [7:0]        errc_q, errc_d;

  logic accept;
  logic out_fire;

  inst_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .inst_o   (pack_inst),
    .reject_o (pack_reject)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // The address register names the held word, so it advances only when that
  // word leaves; a same-cycle accept reloads the word at the new address.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    errc_d  = errc_q;
    if (out_fire) begin
      valid_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(4);
      cnt_d   = cnt_q + 16'd1;
    end
    if (accept) begin
      if (pack_reject) begin
        err_d = 1'b1;
        if (errc_q != '1) errc_d = errc_q + 8'd1;
      end else begin
        valid_d = 1'b1;
        inst_d  = pack_inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_inst   = inst_q;
  assign out_addr   = addr_q;
  assign inst_count = cnt_q;
  assign err        = err_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder -- directed bench for inst_encoder (ADDR_W 12, BASE_ADDR 0xFF0
// so the wrap to 0x000 is reached after four words). Expectations follow
// INST_ENC_RANGE_CHECK_EN when it is defined for the build.
module tb_inst_encoder;
  import inst_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        in_valid, in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [11:0] out_addr;
  logic [15:0] inst_count;
  logic        err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_addr;
  logic [15:0] exp_cnt;
  logic [7:0]  exp_errc;
  logic        exp_err;

  inst_encoder #(.ADDR_W(12), .BASE_ADDR(12'hFF0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .inst_count (inst_count),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One bundle presented for exactly one edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    drive(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Word held with out_ready high: check it, then let it drain and check the advance.
  task automatic expect_word(input string tag, input logic [31:0] word);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, word);
    chk({tag, "_addr"}, {20'b0, out_addr}, {20'b0, exp_addr});
    step();
    exp_addr = exp_addr + 12'd4;
    exp_cnt  = exp_cnt + 16'd1;
    chk({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_next_addr"}, {20'b0, out_addr}, {20'b0, exp_addr});
    chk({tag, "_count"}, {16'b0, inst_count}, {16'b0, exp_cnt});
  endtask

  task automatic expect_reject(input string tag);
    exp_err  = 1'b1;
    exp_errc = exp_errc + 8'd1;
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_errc"}, {24'b0, err_count}, {24'b0, exp_errc});
    chk({tag, "_addr"}, {20'b0, out_addr}, {20'b0, exp_addr});
    chk({tag, "_count"}, {16'b0, inst_count}, {16'b0, exp_cnt});
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();

    // Reset state
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", {20'b0, out_addr}, 32'h0FF0);
    chk("rst_count", {16'b0, inst_count}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_errc", {24'b0, err_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    rst_n = 1'b1; out_ready = 1'b1;
    exp_addr = 12'hFF0; exp_cnt = 16'd0; exp_errc = 8'd0; exp_err = 1'b0;
    step();

    // Format packing, addresses FF0..000 cross the wrap
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 32'd5);
    expect_word("I", 32'h00500093);
    send(FMT_S, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8);
    expect_word("S", 32'h0020A423);
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd4);
    expect_word("B", 32'hFE208EE3);
    send(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    expect_word("J_wrap", 32'h001000EF);
    chk("wrap_to_zero", {20'b0, out_addr}, 32'h0000);
    send(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    expect_word("U", 32'h123452B7);
    send(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFFFFFF);
    expect_word("R", 32'h403100B3);

    // Out-of-range immediates
`ifdef INST_ENC_RANGE_CHECK_EN
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    expect_reject("I_range");
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3);
    expect_reject("B_odd");
`else
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
    expect_word("I_trunc", 32'h80000093);
    chk("no_err", {31'b0, err}, 32'd0);
`endif

    // Reserved format code
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
    expect_reject("fmt_rsvd");

    // Backpressure: word held, in_ready low, then one word per cycle
    out_ready = 1'b0;
    drive(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
    in_valid = 1'b1;
    step();
    drive(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_inst", out_inst, 32'h00100093);
      chk("bp_addr", {20'b0, out_addr}, {20'b0, exp_addr});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    exp_addr = exp_addr + 12'd4;
    chk("bb1_inst", out_inst, 32'h00200093);
    chk("bb1_addr", {20'b0, out_addr}, {20'b0, exp_addr});
    drive(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
    step();
    exp_addr = exp_addr + 12'd4;
    chk("bb2_inst", out_inst, 32'h00300093);
    chk("bb2_addr", {20'b0, out_addr}, {20'b0, exp_addr});
    chk("bb2_count", {16'b0, inst_count}, {16'b0, exp_cnt + 16'd2});
    in_valid = 1'b0;
    step();
    exp_addr = exp_addr + 12'd4;
    exp_cnt  = exp_cnt + 16'd3;
    chk("bb_drain_valid", {31'b0, out_valid}, 32'd0);
    chk("bb_drain_addr", {20'b0, out_addr}, {20'b0, exp_addr});
    chk("bb_drain_count", {16'b0, inst_count}, {16'b0, exp_cnt});

    // Clear with a held word and a pending bundle
    out_ready = 1'b0;
    drive(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd7);
    in_valid = 1'b1;
    step();
    chk("clr_pre_valid", {31'b0, out_valid}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("clr_valid", {31'b0, out_valid}, 32'd0);
    chk("clr_addr", {20'b0, out_addr}, 32'h0FF0);
    chk("clr_count", {16'b0, inst_count}, 32'd0);
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_errc", {24'b0, err_count}, 32'd0);

    // err_count saturation
    drive(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
    in_valid = 1'b1;
    repeat (260) step();
    in_valid = 1'b0;
    chk("sat_errc", {24'b0, err_count}, 32'd255);
    chk("sat_err", {31'b0, err}, 32'd1);
    chk("sat_count", {16'b0, inst_count}, 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd9);
    chk("mrst_pre_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_inst", out_inst, 32'h0);
    chk("mrst_addr", {20'b0, out_addr}, 32'h0FF0);
    chk("mrst_errc", {24'b0, err_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
